pipelined_rippleadder: RTL and testbench
========================================

# pipelined_rippleadder

Parametrised, pipelined successor to the 4-bit ripple-carry adder. Adds two WIDTH-bit operands plus carry-in, rippling SEG bits per pipeline stage and registering the partial carry between stages, so WIDTH can grow without lengthening the critical path. Sits between operand registers and any downstream consumer (accumulator, ALU writeback). A valid/ready handshake provides backpressure, and throughput is one addition per clock.

## Interface
- WIDTH, 16: operand and sum width; must be an integer multiple of SEG.
- SEG, 4: bits resolved per pipeline stage; STAGES = WIDTH/SEG (≥1).
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- In_valid  input  1  A/B/Cin (and Sub) are valid this cycle.
- In_ready  output  1  the pipeline accepts this cycle.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- Cin  input  1  carry into bit 0.
- Sub  input  1  present only when ADDSUB_EN is defined; selects A−B.
- Out_valid  output  1  S/Cout/Ovf hold a result.
- Out_ready  input  1  the consumer takes the result this cycle.
- S  output  WIDTH  sum.
- Cout  output  1  carry out of bit WIDTH−1.
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- STAGES register stages. Stage k adds bits [k·SEG +: SEG] of the operands with the carry registered by stage k−1. Stage 0 uses Cin (or the subtract carry).
- Each stage also carries:
  - already-resolved low sum bits, forwarded;
  - not-yet-added high operand bits, delayed;
  - a valid bit.
- The last stage's registers drive S, Cout, Ovf, Out_valid directly.
- Global advance: adv = ~Out_valid | Out_ready; In_ready = adv.
- When adv=1, every stage loads from its predecessor, and stage 0 loads In_valid/operands. When adv=0, every stage holds, including its valid bit.
- A transaction is accepted on an edge with In_valid & In_ready. Operands with In_valid=0 enter as a bubble (valid 0).
- A result is consumed on an edge with Out_valid & Out_ready.
- Arithmetic: {Cout,S} = A + B + Cin, modulo 2^(WIDTH+1). No sign extension; Ovf is computed per the signed rule.
- The per-stage carry register is exactly 1 bit. The MSB stage additionally registers the carry into bit WIDTH−1 for Ovf.
- Data registers of a stage holding a bubble keep their previous contents. S/Cout/Ovf are meaningful only while Out_valid=1.

## Timing
- Reset: all valid bits, S, Cout, Ovf and all internal data registers are 0. Out_valid=0, so In_ready=1 while RST is low.
- Latency: a transaction accepted at edge n appears with Out_valid=1 after edge n+STAGES−1. With STAGES=1 this is a single registered adder.
- Throughput: with Out_ready held high, one result per cycle; In_ready stays high.
- Stall: Out_valid=1 and Out_ready=0 freeze the entire pipeline, including bubbles. In_ready drops in the same cycle (combinational from Out_ready and Out_valid).
- Accept and consume on the same edge are allowed; both occur.
- RST asserted mid-operation discards all in-flight transactions immediately; no partial result is emitted. The first accept after release follows normal latency.
- Operand changes while In_ready=0 have no effect.

## Configuration
- ADDSUB_EN defined:
  - Sub port exists and is pipelined with the transaction.
  - Sub=1 computes A + ~B + 1, and Cin is ignored.
  - Cout=1 means no borrow (A ≥ B unsigned).
  - Ovf uses the same MSB-carry rule.
- ADDSUB_EN undefined: no Sub port; add only; operand B is never inverted.

## Test plan
(All with WIDTH=16, SEG=4, so STAGES=4.)
- Reset: assert RST with In_valid=1 -> Out_valid=0, S=0, Cout=0, Ovf=0, In_ready=1 after release.
- Single add: A=16'h0FFF, B=16'h0001, Cin=0 accepted at edge 0 -> Out_valid after edge 3, S=16'h1000, Cout=0, Ovf=0. The carry ripples through three stage boundaries.
- Back-to-back with Out_ready=1:
  - Input 1: 16'hFFFF+16'h0001, Cin=0 -> S=0, Cout=1, Ovf=0.
  - Input 2: 16'h7FFF+16'h0001 -> S=16'h8000, Cout=0, Ovf=1.
  - Input 3: 16'h8000+16'h8000, Cin=1 -> S=1, Cout=1, Ovf=1.
  - Required: results on consecutive cycles.
- Backpressure: stream 6 adds and hold Out_ready=0 for 5 cycles mid-stream -> In_ready low exactly while Out_valid&~Out_ready. No result lost or duplicated; order preserved.
- Reset mid-flight: accept 3 transactions, assert RST one cycle later -> no Out_valid ever for them. A new add after release emerges 4 cycles later.
- ADDSUB_EN: Sub=1, A=16'h0005, B=16'h0007, Cin=1 -> S=16'hFFFE, Cout=0. Sub=1, A=16'h8000, B=16'h0001 -> S=16'h7FFF, Cout=1, Ovf=1.

Source files
------------

// File: rtl/pipelined_rippleadder.sv
// pipelined_rippleadder: WIDTH-bit adder split into STAGES = WIDTH/SEG
// register stages. Each stage ripples SEG bits using the 1-bit carry held
// by the previous stage. A global advance signal
// (adv = ~Out_valid | Out_ready) freezes the whole pipeline under
// backpressure.
// Optional feature macro: ADDSUB_EN adds the Sub port. With Sub=1 the
// block computes A + ~B + 1, and Cin is ignored.
module pipelined_rippleadder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef ADDSUB_EN
  input  logic             Sub,
`endif
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned STAGES = WIDTH / SEG;
  localparam int unsigned LAST   = STAGES - 1;

  // Per-stage state: delayed operands, forwarded low sum bits, carry, valid
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];
  logic             r_ovf;

  // Stage inputs (what each stage would load on an advance)
  logic [WIDTH-1:0] w_ain [STAGES];
  logic [WIDTH-1:0] w_bin [STAGES];
  logic [WIDTH-1:0] w_sin [STAGES];
  logic             w_cin [STAGES];
  logic             w_vin [STAGES];
  logic [SEG:0]     w_add [STAGES];
  logic [WIDTH-1:0] w_b0;
  logic             w_c0;
  logic             w_adv;
  logic             w_cmsb;
  logic             w_unused;

`ifdef ADDSUB_EN
  // Subtraction folds into stage 0 as an inverted B plus a forced carry
  assign w_b0 = Sub ? ~B : B;
  assign w_c0 = Sub ? 1'b1 : Cin;
`else
  assign w_b0 = B;
  assign w_c0 = Cin;
`endif

  assign w_adv     = ~r_v[LAST] | Out_ready;
  assign In_ready  = w_adv;
  assign Out_valid = r_v[LAST];
  assign S         = r_s[LAST];
  assign Cout      = r_c[LAST];
  assign Ovf       = r_ovf;

  // The last stage's operand copies are never consumed downstream
  assign w_unused = ^{r_a[LAST], r_b[LAST]};

  // Stage input selection and per-stage SEG-bit ripple addition
  always_comb begin
    w_ain[0] = A;
    w_bin[0] = w_b0;
    w_sin[0] = '0;
    w_cin[0] = w_c0;
    w_vin[0] = In_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_ain[k] = r_a[k-1];
      w_bin[k] = r_b[k-1];
      w_sin[k] = r_s[k-1];
      w_cin[k] = r_c[k-1];
      w_vin[k] = r_v[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_add[k] = {1'b0, w_ain[k][k*SEG +: SEG]}
               + {1'b0, w_bin[k][k*SEG +: SEG]}
               + (SEG+1)'(w_cin[k]);
    end
    // Carry into the MSB recovered from sum bit: s = a ^ b ^ c_in
    w_cmsb = w_ain[LAST][WIDTH-1] ^ w_bin[LAST][WIDTH-1] ^ w_add[LAST][SEG-1];
  end

  // Pipeline registers: all stages advance together or hold together
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_v[k] <= w_vin[k];
        // Bubbles move only the valid bit; data registers hold
        if (w_vin[k]) begin
          r_a[k]               <= w_ain[k];
          r_b[k]               <= w_bin[k];
          r_s[k]               <= w_sin[k];
          r_s[k][k*SEG +: SEG] <= w_add[k][SEG-1:0];
          r_c[k]               <= w_add[k][SEG];
        end
      end
      if (w_vin[LAST]) begin
        r_ovf <= w_cmsb ^ w_add[LAST][SEG];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_rippleadder.sv
// Bench for pipelined_rippleadder (WIDTH=16, SEG=4, four stages).
// A queue-based reference model predicts every result from plain
// arithmetic, and directed vectors pin exact values and cycle timing.
// The Sub vectors are included when ADDSUB_EN is defined.
module tb_pipelined_rippleadder;

  localparam int unsigned W = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          In_valid = 1'b0;
  logic          In_ready;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          Cin = 1'b0;
  logic          Sub = 1'b0;
  logic          Out_valid;
  logic          Out_ready = 1'b1;
  logic [W-1:0]  S;
  logic          Cout;
  logic          Ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];

  pipelined_rippleadder #(.WIDTH(16), .SEG(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .In_valid(In_valid),
    .In_ready(In_ready),
    .A(A),
    .B(B),
    .Cin(Cin),
`ifdef ADDSUB_EN
    .Sub(Sub),
`endif
    .Out_valid(Out_valid),
    .Out_ready(Out_ready),
    .S(S),
    .Cout(Cout),
    .Ovf(Ovf)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: full-width unsigned sum plus signed range test for Ovf
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         r;
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   u;
    int           ss;
    bb = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
    u  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    ss = int'($signed(a)) + int'($signed(bb)) + int'(c);
    r.s = u[W-1:0];
    r.c = u[W];
    r.o = (ss > 32767) || (ss < -32768);
    return r;
  endfunction

  // Compare process: scoreboard against the model every cycle
  always @(negedge CLK) begin
    if (RST) begin
      q.delete();
    end else begin
      check("in_ready_rule", {31'b0, In_ready}, {31'b0, (!Out_valid || Out_ready)});
      if (Out_valid) begin
        check("out_valid_expected", {31'b0, q.size() > 0}, 32'd1);
        if (q.size() > 0) begin
          check("model_S", {16'b0, S}, {16'b0, q[0].s});
          check("model_Cout", {31'b0, Cout}, {31'b0, q[0].c});
          check("model_Ovf", {31'b0, Ovf}, {31'b0, q[0].o});
          if (Out_ready) begin
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      if (In_valid && In_ready) q.push_back(model(A, B, Cin, Sub));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    In_valid = 1'b1;
    A = a;
    B = b;
    Cin = cin;
  endtask

  logic [W-1:0] bb_s [3] = '{16'h0000, 16'h8000, 16'h0001};
  logic         bb_c [3] = '{1'b1, 1'b0, 1'b1};
  logic         bb_o [3] = '{1'b0, 1'b1, 1'b1};
  logic [W-1:0] bp_a [6] = '{16'h1234, 16'hABCD, 16'h7FFF, 16'hFFFF, 16'h8001, 16'h0F0F};
  logic [W-1:0] bp_b [6] = '{16'h4321, 16'h1111, 16'h7FFF, 16'hFFFF, 16'h8001, 16'hF0F0};
  logic         bp_c [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pop0;
    int idx;
    int stalls;
    int seen;
    logic acc;

    // Reset with In_valid asserted
    drive(16'hABCD, 16'h1234, 1'b1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_hold_out_valid", {31'b0, Out_valid}, 32'd0);
    step();
    RST = 1'b0;
    In_valid = 1'b0;
    @(negedge CLK);
    check("rst_out_valid", {31'b0, Out_valid}, 32'd0);
    check("rst_S", {16'b0, S}, 32'd0);
    check("rst_Cout", {31'b0, Cout}, 32'd0);
    check("rst_Ovf", {31'b0, Ovf}, 32'd0);
    check("rst_in_ready", {31'b0, In_ready}, 32'd1);

    // Single add: carry ripples across three stage boundaries
    step();
    drive(16'h0FFF, 16'h0001, 1'b0);
    @(posedge CLK);
    #1 In_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("single_latency", {31'b0, Out_valid}, {31'b0, i == 3});
    end
    check("single_S", {16'b0, S}, 32'h1000);
    check("single_Cout", {31'b0, Cout}, 32'd0);
    check("single_Ovf", {31'b0, Ovf}, 32'd0);
    repeat (3) step();

    // Back-to-back adds, results on consecutive cycles
    drive(16'hFFFF, 16'h0001, 1'b0);
    step();
    drive(16'h7FFF, 16'h0001, 1'b0);
    step();
    drive(16'h8000, 16'h8000, 1'b1);
    step();
    In_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("b2b_valid", {31'b0, Out_valid}, 32'd1);
      check("b2b_S", {16'b0, S}, {16'b0, bb_s[j]});
      check("b2b_Cout", {31'b0, Cout}, {31'b0, bb_c[j]});
      check("b2b_Ovf", {31'b0, Ovf}, {31'b0, bb_o[j]});
    end
    repeat (3) step();

    // Backpressure: six adds, Out_ready low for five cycles mid-stream
    pop0 = n_pop;
    idx = 0;
    stalls = 0;
    for (int c = 0; c < 25; c++) begin
      Out_ready = !(c >= 5 && c < 10);
      if (idx < 6) drive(bp_a[idx], bp_b[idx], bp_c[idx]);
      else In_valid = 1'b0;
      @(negedge CLK);
      if (Out_valid && !Out_ready) stalls++;
      acc = In_valid && In_ready;
      step();
      if (acc) idx++;
    end
    Out_ready = 1'b1;
    check("bp_accepted", idx, 6);
    check("bp_stall_cycles", stalls, 5);
    check("bp_results", n_pop - pop0, 6);
    check("bp_drained", q.size(), 0);

    // Reset mid-flight: three in flight, none may emerge
    drive(16'h1111, 16'h2222, 1'b0);
    step();
    drive(16'h3333, 16'h4444, 1'b0);
    step();
    drive(16'h5555, 16'h6666, 1'b1);
    step();
    RST = 1'b1;
    In_valid = 1'b0;
    repeat (2) step();
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (Out_valid) seen++;
      step();
    end
    check("midrst_no_output", seen, 0);
    drive(16'h0100, 16'h0200, 1'b0);
    @(posedge CLK);
    #1 In_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("midrst_latency", {31'b0, Out_valid}, {31'b0, i == 3});
    end
    check("midrst_S", {16'b0, S}, 32'h0300);
    repeat (3) step();

`ifdef ADDSUB_EN
    // Subtract: Cin ignored, Cout = no borrow
    Sub = 1'b1;
    drive(16'h0005, 16'h0007, 1'b1);
    step();
    drive(16'h8000, 16'h0001, 1'b0);
    step();
    In_valid = 1'b0;
    Sub = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("sub1_valid", {31'b0, Out_valid}, 32'd1);
    check("sub1_S", {16'b0, S}, 32'hFFFE);
    check("sub1_Cout", {31'b0, Cout}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("sub2_S", {16'b0, S}, 32'h7FFF);
    check("sub2_Cout", {31'b0, Cout}, 32'd1);
    check("sub2_Ovf", {31'b0, Ovf}, 32'd1);
    repeat (3) step();
`endif

    // Asynchronous reset clears a stalled, valid result without an edge
    Out_ready = 1'b0;
    drive(16'h00FF, 16'h0F00, 1'b1);
    step();
    In_valid = 1'b0;
    repeat (3) step();
    check("stall_held_valid", {31'b0, Out_valid}, 32'd1);
    check("stall_held_S", {16'b0, S}, 32'h1000);
    check("stall_in_ready", {31'b0, In_ready}, 32'd0);
    RST = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, Out_valid}, 32'd0);
    check("async_rst_S", {16'b0, S}, 32'd0);
    step();
    RST = 1'b0;
    Out_ready = 1'b1;
    repeat (2) step();
    check("final_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
